vga_frame_reader: RTL and testbench

- Display back-end downstream of the processor core.
- Consumes the core's imageSelector and enableVGAX outputs and generates 640x480@60 VGA timing from a 50 MHz system clock.
- Fetches 8-bit grayscale pixels from a synchronous framebuffer RAM and drives the DAC/connector pins.
- Two images are stored back to back in the framebuffer; the core selects which one is shown.

---
 rtl/vga_frame_reader.sv | 130 +++++++++++++
 tb/tb_vga_frame_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// VGA scan-out of one of two grayscale images stored back to back in a synchronous
// framebuffer. The pixel clock is clk/2; odd edges fetch, even edges display.
module vga_frame_reader #(
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int ADDR_W   = 17,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imageSelector,
  input  logic              enableVGAX,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              vga_clk,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_blank_n,
  output logic              vga_sync_n,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_start
);
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int IMG_SHIFT = $clog2(IMG_W);
  localparam int HS_BEG    = H_ACTIVE + H_FP;
  localparam int HS_END    = HS_BEG + H_SYNC;
  localparam int VS_BEG    = V_ACTIVE + V_FP;
  localparam int VS_END    = VS_BEG + V_SYNC;

  logic              r_phase;
  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic              r_sel_q;
  logic              r_en_q;
  logic [ADDR_W-1:0] r_addr;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_blank_n;
  logic              r_fs;
  logic [7:0]        r_grey;

  logic              w_h_last;
  logic              w_v_last;
  logic              w_in_img;
  logic              w_active;
  logic              w_hs_pulse;
  logic              w_vs_pulse;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_pix_addr;
  logic [7:0]        w_grey;

  assign w_h_last   = int'(r_h) == H_TOTAL - 1;
  assign w_v_last   = int'(r_v) == V_TOTAL - 1;
  assign w_in_img   = (int'(r_h) < IMG_W) && (int'(r_v) < IMG_H);
  assign w_active   = (int'(r_h) < H_ACTIVE) && (int'(r_v) < V_ACTIVE);
  assign w_hs_pulse = (int'(r_h) >= HS_BEG) && (int'(r_h) < HS_END);
  assign w_vs_pulse = (int'(r_v) >= VS_BEG) && (int'(r_v) < VS_END);

  // Image width is a power of two, so the row offset is a plain shift.
  assign w_base     = r_sel_q ? ADDR_W'(IMG_W * IMG_H) : '0;
  assign w_pix_addr = w_base + (ADDR_W'(r_v) << IMG_SHIFT) + ADDR_W'(r_h);

  // mem_rdata here answers the address issued on the preceding phase-0 edge,
  // i.e. the same (h,v) the counters still hold.
  assign w_grey = (w_active && r_en_q && w_in_img) ? mem_rdata : 8'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase   <= 1'b0;
      r_h       <= '0;
      r_v       <= '0;
      r_sel_q   <= 1'b0;
      r_en_q    <= 1'b0;
      r_addr    <= '0;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_blank_n <= 1'b0;
      r_fs      <= 1'b0;
      r_grey    <= 8'd0;
    end else begin
      r_phase <= ~r_phase;
      r_fs    <= 1'b0;
      if (!r_phase) begin
        r_addr <= w_in_img ? w_pix_addr : '0;
      end else begin
        r_hsync   <= ~w_hs_pulse;
        r_vsync   <= ~w_vs_pulse;
        r_blank_n <= w_active;
        r_grey    <= w_grey;
        if (w_h_last) begin
          r_h <= '0;
          if (w_v_last) begin
            // Image choice and enable only change at frame boundaries.
            r_v     <= '0;
            r_sel_q <= imageSelector;
            r_en_q  <= enableVGAX;
            r_fs    <= 1'b1;
          end else begin
            r_v <= r_v + VW'(1);
          end
        end else begin
          r_h <= r_h + HW'(1);
        end
      end
    end
  end

  assign mem_addr    = r_addr;
  assign vga_clk     = r_phase;
  assign vga_hsync   = r_hsync;
  assign vga_vsync   = r_vsync;
  assign vga_blank_n = r_blank_n;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = r_grey;
  assign vga_g       = r_grey;
  assign vga_b       = r_grey;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomized bench for vga_frame_reader on a shrunk raster, checked every cycle
// against a model that derives all outputs from the clock count since reset.
module tb_vga_frame_reader;
  localparam int IW = 16, IH = 8, AW = 9;
  localparam int HA = 40, HFP = 4, HS = 6, HBP = 6, HT = HA + HFP + HS + HBP;
  localparam int VA = 20, VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
  localparam int F = HT * VT;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imageSelector = 1'b0;
  logic          enableVGAX = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          vga_clk, vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start;
  logic [7:0]    vga_r, vga_g, vga_b;

  logic [7:0] ram [0:(1<<AW)-1];
  int  tests = 0, errors = 0;
  int  n = 0;
  bit  fr_sel [0:15];
  bit  fr_en  [0:15];

  always #10 clk = ~clk;

  vga_frame_reader #(
    .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset(reset), .imageSelector(imageSelector), .enableVGAX(enableVGAX),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .vga_clk(vga_clk),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  // The registered mem_addr plays the role of the RAM's address register.
  initial for (int a = 0; a < (1 << AW); a++) ram[a] = 8'(a) ^ 8'h80;
  assign mem_rdata = ram[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_addr(input int h, input int v, input bit s);
    if (h < IW && v < IH) return (s ? IW * IH : 0) + v * IW + h;
    return 0;
  endfunction

  function automatic int clampf(input int f);
    return (f > 15) ? 15 : f;
  endfunction

  // Edge counter; pixel tick t happens on edge 2t, and the tick ending frame k-1
  // latches the inputs used by frame k.
  always @(posedge clk) begin
    if (reset) begin
      n = 0;
      fr_sel[0] = 1'b0;
      fr_en[0]  = 1'b0;
    end else begin
      n++;
      if (n % 2 == 0 && (n / 2) % F == 0) begin
        fr_sel[clampf(n / 2 / F)] = imageSelector;
        fr_en[clampf(n / 2 / F)]  = enableVGAX;
      end
    end
  end

  always @(negedge clk) begin
    int np, t, pos, fr, h, v;
    logic ehs, evs, ebl, efs;
    logic [7:0] eg;
    if (reset || n == 0) begin
      chk("reset_addr", 32'(mem_addr), 32'd0);
      chk("reset_out", {vga_clk, vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start,
                        vga_r, vga_g, vga_b}, {6'b011000, 24'd0});
    end else begin
      efs = (n % 2 == 0) && ((n / 2) % F == 0);
      chk("clk_sync_fs", {vga_clk, vga_sync_n, frame_start}, {1'(n % 2), 1'b0, efs});
      np  = (n % 2 == 1) ? n : n - 1;
      t   = (np - 1) / 2;
      pos = t % F;
      fr  = clampf(t / F);
      chk("addr", 32'(mem_addr), 32'(exp_addr(pos % HT, pos / HT, fr_sel[fr])));
      if (n >= 2) begin
        np  = n - n % 2;
        t   = np / 2 - 1;
        pos = t % F;
        fr  = clampf(t / F);
        h   = pos % HT;
        v   = pos / HT;
        ehs = !(h >= HA + HFP && h < HA + HFP + HS);
        evs = !(v >= VA + VFP && v < VA + VFP + VS);
        ebl = h < HA && v < VA;
        eg  = (ebl && fr_en[fr] && h < IW && v < IH) ? ram[exp_addr(h, v, fr_sel[fr])] : 8'd0;
      end else begin
        ehs = 1'b1; evs = 1'b1; ebl = 1'b0; eg = 8'd0;
      end
      chk("pixel_out", {vga_hsync, vga_vsync, vga_blank_n, vga_r, vga_g, vga_b},
          {ehs, evs, ebl, eg, eg, eg});
    end
  end

  int cyc = 0, last_fs = -1, fs_period = 0;
  int hs_run = 0, hs_last = 0, vs_run = 0, vs_last = 0;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      last_fs = -1; fs_period = 0; hs_run = 0; vs_run = 0;
    end else begin
      if (frame_start) begin
        if (last_fs >= 0) fs_period = cyc - last_fs;
        last_fs = cyc;
      end
      if (!vga_hsync) hs_run++;
      else if (hs_run > 0) begin hs_last = hs_run; hs_run = 0; end
      if (!vga_vsync) vs_run++;
      else if (vs_run > 0) begin vs_last = vs_run; vs_run = 0; end
    end
  end

  task automatic wait_n(input int target);
    while (n < target) @(negedge clk);
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    imageSelector = 1'b0;
    enableVGAX = 1'b1;

    // Frame 1: image 0 shown. Pixel (5,3) -> addr 53 -> 0x35^0x80.
    wait_n(2 * (F + 3 * HT + 5 + 1));
    chk("pix_5_3_rgb", 32'(vga_r), 32'h0B5);
    wait_n(2 * (F + 3 * HT + 20 + 1));
    chk("pix_20_3_rgb", 32'({vga_blank_n, vga_g}), 32'h100);
    // Mid-frame selector change must not affect the rest of this frame.
    wait_n(2 * (F + 4 * HT));
    imageSelector = 1'b1;
    wait_n(2 * (F + 6 * HT + 3 + 1));
    chk("pix_3_6_oldbase", 32'(vga_b), 32'h0E3);

    // Frame 2: image 1.
    wait_n(2 * (2 * F) + 1);
    chk("addr_img1_first", 32'(mem_addr), 32'd128);
    wait_n(2 * (2 * F + 1 + 1));
    chk("pix_1_0_img1", 32'(vga_r), 32'h001);
    wait_n(2 * (2 * F + 7 * HT + 15) + 1);
    chk("addr_img1_last", 32'(mem_addr), 32'd255);
    enableVGAX = 1'b0;

    // Frame 3: disabled, timing unchanged.
    wait_n(2 * (3 * F + 3 * HT + 5 + 1));
    chk("pix_disabled", 32'({vga_blank_n, vga_hsync, vga_vsync, vga_r}), 32'h700);
    chk("frame_period", 32'(fs_period), 32'(2 * F));
    chk("hsync_low_clk", 32'(hs_last), 32'(2 * HS));
    chk("vsync_low_clk", 32'(vs_last), 32'(2 * VS * HT));

    // Frames 3-4: random selector/enable activity.
    while (n < 2 * 5 * F - 2) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) imageSelector = ~imageSelector;
      if ($urandom_range(0, 59) == 0) enableVGAX = ~enableVGAX;
    end
    // Change lands on the very edge that latches frame 5.
    wait_n(2 * 5 * F - 1);
    imageSelector = ~imageSelector;
    enableVGAX = 1'b1;

    // Mid-frame reset at pixel (20,10) of frame 5.
    wait_n(2 * (5 * F + 10 * HT + 20));
    #3 reset = 1'b1;
    #1;
    chk("midreset_addr", 32'(mem_addr), 32'd0);
    chk("midreset_out", {vga_clk, vga_hsync, vga_vsync, vga_blank_n, frame_start, vga_r},
        {5'b01100, 8'd0});
    repeat (3) @(negedge clk);
    reset = 1'b0;
    k = 0;
    while (!frame_start && k < 2 * F + 20) begin
      @(negedge clk);
      k++;
    end
    chk("fs_after_reset", 32'(k), 32'(2 * F));
    k = 0;
    repeat (3) @(negedge clk);
    while (!frame_start && k < 2 * F + 20) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    chk("frame_period_post_reset", 32'(fs_period), 32'(2 * F));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
